l2_read_arbiter: RTL
====================

# l2_read_arbiter

Parametrised read-side L2 port arbiter: it merges `NUM_CH` cache read channels onto one L2 read address/data port. Examples of read channels are the instruction-cache miss port and the data-cache read port. Address requests are granted round-robin. Granted channel IDs are queued in order of issue, and returning burst data is steered back to the requester at the head of that queue. The block sits between the processor top's caches and the memory/L2 model, replacing point-to-point cache-to-L2 read wiring.

## Interface
Parameters:
- `NUM_CH`, 2, number of requesting read channels (2..8).
- `W`, 7, data beat width is 2^W bits (`L2_BUS_WIDTH`).
- `B`, 9, cache block size is 2^B bits; burst length `L2_BURST` = 2^(B-W) beats.
- `Q`, 2, outstanding-request queue depth is 2^Q.
- `ADDR_WIDTH`, 32 (fixed); L2 addresses are word addresses, `ADDR_WIDTH-2` = 30 bits.

Ports:
- `CLK`  in  1  clock; all logic on rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `ADDR_IN`  in  NUM_CH*30  per-channel word address; channel i occupies bits [30i+29:30i].
- `ADDR_IN_VALID`  in  NUM_CH  per-channel request valid.
- `ADDR_IN_READY`  out  NUM_CH  per-channel accept; one-hot or zero.
- `ADDR_TO_L2`  out  30  registered granted address.
- `ADDR_TO_L2_VALID`  out  1  address valid toward L2.
- `ADDR_TO_L2_READY`  in  1  L2 accepts address.
- `DATA_FROM_L2`  in  2^W  returning beat.
- `DATA_FROM_L2_VALID`  in  1  beat valid.
- `DATA_FROM_L2_READY`  out  1  beat accepted.
- `DATA_OUT`  out  2^W  beat broadcast to all channels, equal to `DATA_FROM_L2` (combinational).
- `DATA_OUT_VALID`  out  NUM_CH  one-hot valid to the owning channel.
- `DATA_OUT_READY`  in  NUM_CH  per-channel data ready.
- `BUSY`  out  1  queue non-empty or address register occupied.

## Operation
- **Address stage.** The output register is free when `!ADDR_TO_L2_VALID || ADDR_TO_L2_READY`.
- **Grant.** When the register is free and the queue count < 2^Q, the arbiter grants the first valid channel found searching from pointer `rr_ptr` upward with wrap.
- **Accept.** `ADDR_IN_READY[g]`=1 only for the granted channel, combinationally in that cycle. On acceptance the address is loaded into `ADDR_TO_L2`, `ADDR_TO_L2_VALID` is set, `g` is pushed into the ID queue, and `rr_ptr` becomes (g+1) mod NUM_CH.
- **Full queue.** A full queue blocks grants even if a pop occurs in the same cycle.
- **Push/pop.** Simultaneous push and pop on a non-full queue leaves the count unchanged.
- **Data stage.** When the queue is empty, `DATA_FROM_L2_READY`=0 and `DATA_OUT_VALID`=0. Otherwise, with head ID h:
  - `DATA_OUT_VALID[h]` = `DATA_FROM_L2_VALID`;
  - `DATA_FROM_L2_READY` = `DATA_OUT_READY[h]`.
- **Beat counting.** Beat counter `beat` (width B-W, min 1) increments on each beat handshake. On the handshake with `beat == L2_BURST-1` the counter wraps to 0 and the head is popped.
- **Ordering.** Bursts return strictly in address-issue order; there is no reordering.

## Timing
- **Reset values.** `ADDR_TO_L2_VALID`=0, `ADDR_TO_L2`=0, `rr_ptr`=0, `beat`=0, queue empty. Consequently `ADDR_IN_READY`=0, `DATA_OUT_VALID`=0, `DATA_FROM_L2_READY`=0 and `BUSY`=0.
- **Address latency.** One cycle from `ADDR_IN` handshake to `ADDR_TO_L2_VALID`. Back-to-back grants are possible every cycle while `ADDR_TO_L2_READY`=1.
- **Address hold.** `ADDR_TO_L2` and `ADDR_TO_L2_VALID` are held stable until the L2 handshake.
- **Data path.** Zero cycles: purely combinational steering from the queue head.
- **Beat pacing.** A burst may take any number of cycles; stalls by either side hold `beat`.
- **Pop to next burst.** The next burst's first beat may be accepted in the cycle after the pop.
- **Reset mid-operation.** Outstanding bursts, the queue and the register are discarded in the same cycle. Upstream and downstream must also be reset.

## Structure
- Shared package/include: `L2_ADDR_WIDTH` (30), `L2_BUS_WIDTH` = 1<<W, `L2_BURST` = 1<<(B-W), and the clog2 function used for the ID and beat widths.
- Sub-module `l2_req_id_fifo`: synchronous FIFO, depth 2^Q, width clog2(NUM_CH). It provides push/pop, head, count, full and empty.
- Round-robin selection and beat counting live in the top module.

## Test plan
- **Single request.** NUM_CH=2, ch1 requests 0x100 with L2 ready → `ADDR_IN_READY`=2'b10, next cycle `ADDR_TO_L2`=0x100 valid. L2 returns 4 beats (B=9, W=7) → `DATA_OUT_VALID`=2'b10 on each beat, queue empty after the 4th beat.
- **Fairness.** Both channels continuously valid, L2 always ready → grants alternate 0,1,0,1 starting with ch0 after reset.
- **Queue full.** Q=2, L2 takes addresses but returns no data → exactly 4 grants, then `ADDR_IN_READY`=0. After one full burst completes, exactly one further grant occurs.
- **Ordering and backpressure.** Issue ch0 then ch1; hold `DATA_OUT_READY[0]`=0 for 3 cycles mid-burst → `DATA_FROM_L2_READY`=0 and `beat` frozen. Ch1 never sees valid until ch0's 4th beat is accepted.
- **Address stall.** `ADDR_TO_L2_READY`=0 for 5 cycles → `ADDR_TO_L2` stays stable and no new grant occurs; stray `DATA_FROM_L2_VALID` with the queue empty sees ready=0.
- **Reset mid-burst.** Assert `RST` after beat 2 → next cycle all outputs at reset values and `beat`=0.

Source files
------------

// File: rtl/l2_read_arbiter_pkg.sv
// Shared constants and helpers for the L2 read-port arbiter.
package l2_read_arbiter_pkg;

  // L2 addresses are 32-bit word addresses with the byte offset dropped
  localparam int unsigned L2_ADDR_WIDTH = 30;

  // Ceiling log2, never less than 1 so single-entry fields still get a bit
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r++;
    if (r == 0) r = 1;
    return r;
  endfunction

  // Data beat width in bits for a given W
  function automatic int unsigned l2_bus_width(input int unsigned w);
    return 32'd1 << w;
  endfunction

  // Beats per cache block for a given B and W
  function automatic int unsigned l2_burst(input int unsigned b, input int unsigned w);
    return 32'd1 << (b - w);
  endfunction

  // Values for the default configuration (W=7, B=9)
  localparam int unsigned L2_BUS_WIDTH = l2_bus_width(7);
  localparam int unsigned L2_BURST     = l2_burst(9, 7);

endpackage

// File: rtl/l2_read_arbiter_req_id_fifo.sv
// In-order queue of granted channel IDs awaiting their data bursts.
module l2_req_id_fifo
  import l2_read_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 2,
  parameter int unsigned DATA_W     = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_push,
  input  logic [DATA_W-1:0]     i_push_data,
  input  logic                  i_pop,
  output logic [DATA_W-1:0]     o_head_c,
  output logic [DEPTH_LOG2:0]   o_count,
  output logic                  o_full_c,
  output logic                  o_empty_c
);

  localparam int unsigned DEPTH = 32'd1 << DEPTH_LOG2;

  logic [DATA_W-1:0]     r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  w_do_push;
  logic                  w_do_pop;

  assign o_full_c  = (r_count == (DEPTH_LOG2+1)'(DEPTH));
  assign o_empty_c = (r_count == '0);
  assign o_head_c  = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  // Overflow and underflow requests are ignored rather than corrupting state
  assign w_do_push = i_push && !o_full_c;
  assign w_do_pop  = i_pop && !o_empty_c;

  // Pointer and occupancy tracking
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + DEPTH_LOG2'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (DEPTH_LOG2+1)'(1);
        2'b01:   r_count <= r_count - (DEPTH_LOG2+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array; contents are don't-care until pushed, so no reset
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
  end

endmodule

// File: rtl/l2_read_arbiter.sv
// Merges NUM_CH cache read channels onto a single L2 read port:
// round-robin address grant, in-order ID queue, combinational data steering.
module l2_read_arbiter
  import l2_read_arbiter_pkg::*;
#(
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned W          = 7,
  parameter int unsigned B          = 9,
  parameter int unsigned Q          = 2,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                                CLK,
  input  logic                                RST,
  input  logic [NUM_CH*(ADDR_WIDTH-2)-1:0]    ADDR_IN,
  input  logic [NUM_CH-1:0]                   ADDR_IN_VALID,
  output logic [NUM_CH-1:0]                   ADDR_IN_READY,
  output logic [ADDR_WIDTH-3:0]               ADDR_TO_L2,
  output logic                                ADDR_TO_L2_VALID,
  input  logic                                ADDR_TO_L2_READY,
  input  logic [l2_bus_width(W)-1:0]          DATA_FROM_L2,
  input  logic                                DATA_FROM_L2_VALID,
  output logic                                DATA_FROM_L2_READY,
  output logic [l2_bus_width(W)-1:0]          DATA_OUT,
  output logic [NUM_CH-1:0]                   DATA_OUT_VALID,
  input  logic [NUM_CH-1:0]                   DATA_OUT_READY,
  output logic                                BUSY
);

  localparam int unsigned AW    = ADDR_WIDTH - 2;
  localparam int unsigned BURST = l2_burst(B, W);
  localparam int unsigned IDW   = clog2(NUM_CH);
  localparam int unsigned BW    = clog2(BURST);

  // Registered state
  logic [AW-1:0]  r_addr;
  logic           r_addr_valid;
  logic [IDW-1:0] r_rr_ptr;
  logic [BW-1:0]  r_beat;

  // Arbitration wires
  logic [AW-1:0]         w_ch_addr [NUM_CH];
  logic [2*NUM_CH-1:0]   w_req_rot;
  logic                  w_gnt_found;
  logic [IDW-1:0]        w_gnt_id;
  logic [IDW-1:0]        w_next_ptr;
  logic                  w_reg_free;
  logic                  w_can_grant;
  logic                  w_accept;

  // Queue and data-stage wires
  logic [IDW-1:0] w_q_head;
  logic [Q:0]     w_q_count;
  logic           w_q_full;
  logic           w_q_empty;
  logic           w_beat_hs;
  logic           w_beat_last;
  logic           w_pop;

  // Split the flat address bus into one entry per channel
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_addr_split
    assign w_ch_addr[gi] = ADDR_IN[gi*AW +: AW];
  end

  // The address register can take a new entry if empty or draining this cycle
  assign w_reg_free  = !r_addr_valid || ADDR_TO_L2_READY;
  // Full is checked on registered occupancy, so a same-cycle pop does not help
  assign w_can_grant = w_reg_free && !w_q_full;

  // Rotate the request vector so bit 0 corresponds to rr_ptr
  assign w_req_rot = {ADDR_IN_VALID, ADDR_IN_VALID} >> r_rr_ptr;

  // First valid channel at or after rr_ptr, with wrap
  always_comb begin
    w_gnt_found = 1'b0;
    w_gnt_id    = '0;
    w_next_ptr  = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (!w_gnt_found && w_req_rot[i]) begin
        w_gnt_found = 1'b1;
        w_gnt_id    = IDW'((int'(r_rr_ptr) + i) % int'(NUM_CH));
        w_next_ptr  = IDW'((int'(r_rr_ptr) + i + 1) % int'(NUM_CH));
      end
    end
  end

  assign w_accept = w_gnt_found && w_can_grant && !RST;

  // One-hot accept toward the granted channel
  always_comb begin
    ADDR_IN_READY = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      ADDR_IN_READY[i] = w_accept && (w_gnt_id == IDW'(i));
    end
  end

  // Address output register and round-robin pointer
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_addr       <= '0;
      r_addr_valid <= 1'b0;
      r_rr_ptr     <= '0;
    end else if (w_accept) begin
      r_addr       <= w_ch_addr[w_gnt_id];
      r_addr_valid <= 1'b1;
      r_rr_ptr     <= w_next_ptr;
    end else if (ADDR_TO_L2_READY) begin
      r_addr_valid <= 1'b0;
    end
  end

  assign ADDR_TO_L2       = r_addr;
  assign ADDR_TO_L2_VALID = r_addr_valid;

  // Outstanding-request ID queue, pushed on grant and popped on last beat
  l2_req_id_fifo #(
    .DEPTH_LOG2 (Q),
    .DATA_W     (IDW)
  ) u_id_fifo (
    .i_clk       (CLK),
    .i_rst       (RST),
    .i_push      (w_accept),
    .i_push_data (w_gnt_id),
    .i_pop       (w_pop),
    .o_head_c    (w_q_head),
    .o_count     (w_q_count),
    .o_full_c    (w_q_full),
    .o_empty_c   (w_q_empty)
  );

  // Steer the returning beat to the channel at the head of the queue
  always_comb begin
    DATA_OUT_VALID     = '0;
    DATA_FROM_L2_READY = 1'b0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (!w_q_empty && (w_q_head == IDW'(i))) begin
        DATA_OUT_VALID[i]  = DATA_FROM_L2_VALID;
        DATA_FROM_L2_READY = DATA_OUT_READY[i];
      end
    end
  end

  assign DATA_OUT    = DATA_FROM_L2;
  assign w_beat_hs   = DATA_FROM_L2_VALID && DATA_FROM_L2_READY;
  assign w_beat_last = (r_beat == BW'(BURST - 1));
  assign w_pop       = w_beat_hs && w_beat_last;

  // Beat counter within the current burst; wraps to 0 on the last beat
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_beat <= '0;
    end else if (w_beat_hs) begin
      r_beat <= w_beat_last ? '0 : r_beat + BW'(1);
    end
  end

  assign BUSY = (w_q_count != '0) || r_addr_valid;

endmodule
